// File: rtl/decode_table_pkg.sv
// Decode constants and divide-sequencer state encoding shared by the EX stage.
package decode_table_pkg;
  localparam logic [5:0] R_DIV  = 6'b011010;
  localparam logic [5:0] R_DIVU = 6'b011011;
  localparam int DIV_ITER = 32;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, DIV_OP, DIVU_OP} alu_op_t;
  typedef enum logic [1:0] {RES_ALU, RES_SHIFT, RES_DIV} alu_sel_t;
  typedef enum logic [1:0] {IDLE, DIV_ZERO, ON, END} div_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {rem, quo} pair.
module div_step
  import decode_table_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // rem < divisor on entry, so a successful subtract always fits in WIDTH bits
  assign upper    = {rem, quo[WIDTH-1]};
  assign fits     = upper >= {1'b0, divisor};
  assign diff     = upper[WIDTH-1:0] - divisor;
  assign rem_next = fits ? diff : upper[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};
endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer beside the EX ALU: WIDTH-step restoring divide, stalls EX until ready.
// Optional DIV_ZERO_EXC_EN adds div_zero_o, flagging results that came from a zero divisor.
module div_ctrl
  import decode_table_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o,
`ifdef DIV_ZERO_EXC_EN
  output logic               div_zero_o,
`endif
  output logic               busy_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] abs_dividend, abs_divisor, rem_fix, quo_fix;
  logic             quo_neg, rem_neg;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  assign accept       = start_i && !annul_i;
  assign abs_dividend = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign abs_divisor  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
  // WIDTH-bit negation wraps, so most-negative / -1 yields the most-negative quotient
  assign quo_fix      = quo_neg ? -quo : quo;
  assign rem_fix      = rem_neg ? -rem : rem;

  assign stall_o = start_i && !ready_o && !annul_i;
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = (divisor_i == '0) ? DIV_ZERO : ON;
      DIV_ZERO: state_nxt = END;
      ON: begin
        if (annul_i)          state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = END;
      end
      END:      if (annul_i || (ready_o && !start_i)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      quo_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rem     <= '0;
          quo     <= abs_dividend;
          dvsr    <= abs_divisor;
          quo_neg <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
          rem_neg <= signed_i && dividend_i[WIDTH-1];
          cnt     <= '0;
        end
        DIV_ZERO: begin
          rem      <= '0;
          quo      <= '0;
          quo_neg  <= 1'b0;
          rem_neg  <= 1'b0;
          result_o <= '0;
        end
        ON: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
        end
        END: begin
          if (annul_i) begin
            ready_o <= 1'b0;
          end else if (!ready_o) begin
            ready_o  <= 1'b1;
            result_o <= {rem_fix, quo_fix};
          end else if (!start_i) begin
            ready_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_EXC_EN
  logic from_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      from_zero  <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      if (state == IDLE && accept) from_zero <= (divisor_i == '0);
      if (state == END) begin
        if (annul_i)       div_zero_o <= 1'b0;
        else if (!ready_o) div_zero_o <= from_zero;
        else if (!start_i) div_zero_o <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table plus annul, mid-run reset and back-to-back sequences.
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start_i, signed_i, annul_i;
  logic [31:0] dividend_i, divisor_i;
  logic [63:0] result_o;
  logic        ready_o, stall_o, busy_o;
`ifdef DIV_ZERO_EXC_EN
  logic        div_zero_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_o    (stall_o),
`ifdef DIV_ZERO_EXC_EN
    .div_zero_o (div_zero_o),
`endif
    .busy_o     (busy_o)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge where start_i is dropped.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int elat,
                         input string tag, input logic chk_hold, input logic [63:0] hold_val);
    int cyc = 0;
    int stall_bad = 0;
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
    while (ready_o !== 1'b1 && cyc < 100) begin
      #1;
      if (stall_o !== 1'b1) stall_bad++;
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        dividend_i = $urandom;
        divisor_i  = '0;
      end
      if (chk_hold && cyc == 5) check({tag, "_held"}, result_o, hold_val);
    end
    check({tag, "_latency"}, 64'(cyc - 1), 64'(elat));
    check({tag, "_stall_gaps"}, 64'(stall_bad), 64'd0);
    check({tag, "_stall_at_ready"}, {63'd0, stall_o}, 64'd0);
    check({tag, "_result"}, result_o, {er, eq});
`ifdef DIV_ZERO_EXC_EN
    check({tag, "_div_zero"}, {63'd0, div_zero_o}, {63'd0, (b == 32'd0)});
`endif
    start_i = 1'b0;
  endtask

  task automatic post_check(input string tag, input logic [63:0] held);
    @(negedge clk);
    check({tag, "_ready_clr"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_busy_clr"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_result_hold"}, result_o, held);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{1'b0, 32'd7,          32'd2,          32'd3,          32'd1,          33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          2};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33};
    vecs[7]  = '{1'b0, 32'd3,          32'd7,          32'd0,          32'd3,          33};
    vecs[8]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          33};
    vecs[9]  = '{1'b0, 32'h1234_5678,  32'h0000_0100,  32'h0012_3456,  32'h78,         33};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'd0,          32'd0,          32'd0,          2};
    vecs[11] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          33};

    rst_n = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result_o, 64'd0);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_stall", {63'd0, stall_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat,
              $sformatf("vec%0d", i), 1'b0, 64'd0);
      post_check($sformatf("vec%0d", i), {vecs[i].r, vecs[i].q});
    end

    // Annul in the middle of ON: abort, no ready, then a clean division.
    start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'd12345; divisor_i = 32'd3;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    #1 check("annul_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    check("annul_busy", {63'd0, busy_o}, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o === 1'b1 || busy_o === 1'b1) seen++;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    run_div(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 33, "after_annul", 1'b0, 64'd0);
    post_check("after_annul", {32'd2, 32'd14});

    // Synchronous reset while ON clears everything, including the held result.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd123; divisor_i = 32'd4;
    repeat (21) @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("midrst_result", result_o, 64'd0);
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, "after_rst", 1'b0, 64'd0);
    post_check("after_rst", {32'd0, 32'hFFFF_FFFF});

    // Back-to-back: drop start the cycle after ready, re-assert the following cycle.
    run_div(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 33, "b2b_first", 1'b0, 64'd0);
    post_check("b2b_gap", {32'd1, 32'd3});
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, "b2b_second", 1'b1, {32'd1, 32'd3});
    post_check("b2b_second", {32'd0, 32'd3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
